noc_inject_sched: RTL

- Injection scheduler in front of one router input channel.
- Shares the channel among NUM_REQ local flit sources.
- Tracks per-VC downstream credits returned on the router's flow-control path, and locks each VC to one source for the duration of a packet.
- Emits at most one registered flit per cycle.

---
 rtl/noc_inject_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/noc_inject_sched.sv
// Injection scheduler: round-robin over NUM_REQ local sources into one router
// input channel, with per-VC credit tracking and per-packet VC locking.

module noc_inject_elig #(
  parameter int NUM_VC = 2,
  parameter int VC_W   = 1,
  parameter int CNT_W  = 4,
  parameter int REQ_W  = 2
) (
  input  logic [REQ_W-1:0]              src_idx_i,
  input  logic                          valid_i,
  input  logic                          head_i,
  input  logic [VC_W-1:0]               vc_i,
  input  logic [NUM_VC-1:0]             busy_i,
  input  logic [NUM_VC-1:0][REQ_W-1:0]  owner_i,
  input  logic [NUM_VC-1:0][CNT_W-1:0]  credit_i,
  output logic                          elig_o,
  output logic                          perr_o
);
  logic owned, has_cr;

  assign owned  = busy_i[vc_i] && (owner_i[vc_i] == src_idx_i);
  assign has_cr = (credit_i[vc_i] != '0);
  // A head from another source on a busy VC just waits; only the owner re-heading
  // or a body flit from a non-owner is a protocol violation.
  assign perr_o = valid_i && (head_i ? owned : !owned);
  assign elig_o = valid_i && has_cr && (head_i ? !busy_i[vc_i] : owned);
endmodule

module noc_inject_sched #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_VC    = 2,
  parameter int VC_W      = 1,
  parameter int FLIT_W    = 32,
  parameter int BUF_DEPTH = 8,
  parameter int CNT_W     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ*VC_W-1:0]   req_vc,
  input  logic [NUM_REQ-1:0]        req_head,
  input  logic [NUM_REQ-1:0]        req_tail,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      credit_valid,
  input  logic [VC_W-1:0]           credit_vc,
  output logic                      out_valid,
  output logic [FLIT_W-1:0]         out_flit,
  output logic [VC_W-1:0]           out_vc,
  output logic                      out_head,
  output logic                      out_tail,
  output logic [NUM_VC-1:0]         vc_busy,
  output logic                      sched_error
);
  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_VC-1:0][CNT_W-1:0]  credit_q, credit_d;
  logic [NUM_VC-1:0]             busy_q;
  logic [NUM_VC-1:0][REQ_W-1:0]  owner_q;
  logic [REQ_W-1:0]              ptr_q;
  logic                          err_q;
  logic                          vld_q, head_q, tail_q;
  logic [FLIT_W-1:0]             flit_q;
  logic [VC_W-1:0]               vc_q;

  logic [NUM_REQ-1:0][FLIT_W-1:0] flit_a;
  logic [NUM_REQ-1:0][VC_W-1:0]   vc_a;
  logic [NUM_REQ-1:0]             elig, perr, grant;
  logic [REQ_W-1:0]               gidx;
  logic                           found, cr_ovf;
  logic [VC_W-1:0]                g_vc;

  assign flit_a = req_flit;
  assign vc_a   = req_vc;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
    noc_inject_elig #(
      .NUM_VC(NUM_VC), .VC_W(VC_W), .CNT_W(CNT_W), .REQ_W(REQ_W)
    ) u_elig (
      .src_idx_i (REQ_W'(i)),
      .valid_i   (req_valid[i]),
      .head_i    (req_head[i]),
      .vc_i      (vc_a[i]),
      .busy_i    (busy_q),
      .owner_i   (owner_q),
      .credit_i  (credit_q),
      .elig_o    (elig[i]),
      .perr_o    (perr[i])
    );
  end

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gidx  = '0;
    grant = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = REQ_W'(idx);
      end
    end
    grant[gidx] = found;
  end

  assign g_vc      = vc_a[gidx];
  assign req_ready = grant & {NUM_REQ{reset}};

  // Simultaneous grant and return on one VC cancel out, so that case never overflows.
  always_comb begin
    logic dec, inc;
    dec      = 1'b0;
    inc      = 1'b0;
    credit_d = credit_q;
    cr_ovf   = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      dec = found && (g_vc == VC_W'(v));
      inc = credit_valid && (credit_vc == VC_W'(v));
      if (dec && !inc) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end else if (inc && !dec) begin
        if (credit_q[v] == CNT_W'(BUF_DEPTH)) cr_ovf = 1'b1;
        else                                  credit_d[v] = credit_q[v] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) credit_q[v] <= CNT_W'(BUF_DEPTH);
      busy_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      flit_q  <= '0;
      vc_q    <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_q | (|perr) | cr_ovf;
      vld_q    <= found;
      if (found) begin
        ptr_q  <= (gidx == REQ_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        flit_q <= flit_a[gidx];
        vc_q   <= g_vc;
        head_q <= req_head[gidx];
        tail_q <= req_tail[gidx];
        if (req_tail[gidx]) begin
          busy_q[g_vc] <= 1'b0;
        end else if (req_head[gidx]) begin
          busy_q[g_vc]  <= 1'b1;
          owner_q[g_vc] <= gidx;
        end
      end
    end
  end

  assign out_valid   = vld_q;
  assign out_flit    = flit_q;
  assign out_vc      = vc_q;
  assign out_head    = head_q;
  assign out_tail    = tail_q;
  assign vc_busy     = busy_q;
  assign sched_error = err_q;
endmodule
